id_ex_pipe_reg: RTL and testbench

//   Parametrised ID/EX pipeline register for the RISC-V core with valid/ready handshake.

---
 rtl/id_ex_pipe_reg.sv | 163 ++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline register for the RISC-V core. It uses a valid/ready
//   handshake and carries the decoded control bundle, PC, operands, immediate,
//   funct field and rd from decode to execute.
//   The register also supports backpressure stall, synchronous flush, bubble
//   insertion on drain, and a saturating stall counter.
//
//   Optional feature macro: LOAD_USE_HAZARD_EN
//     When it is defined, a load-use hazard check holds off the consumer of a
//     load for one cycle, so exactly one bubble is inserted.
//     When it is undefined, the hazard signal is tied to 0. The ports
//     rs1_addr, rs2_addr and uses_rs2 stay on the module but are ignored.
//
// Ports
//   clk                     clock, all state updates on the rising edge
//   reset                   asynchronous active-low reset
//   flush                   synchronous kill of the held entry
//   in_valid / in_ready     decode-side handshake (in_ready is combinational)
//   ctrl_in .. rd_in        payload captured on an accepted handshake
//   rs1_addr, rs2_addr,
//   uses_rs2                source operand info for the hazard check
//   out_valid / out_ready   execute-side handshake
//   ctrl_out .. rd_out      registered payload
//   stall_cnt               saturating count of cycles with in_valid && !in_ready
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int XLEN    = 64,
  parameter int CTRL_W  = 8,
  parameter int FUNCT_W = 4,
  parameter int RD_W    = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic [XLEN-1:0]    pc_in,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [XLEN-1:0]    imm_in,
  input  logic [FUNCT_W-1:0] funct_in,
  input  logic [RD_W-1:0]    rd_in,
  input  logic [RD_W-1:0]    rs1_addr,
  input  logic [RD_W-1:0]    rs2_addr,
  input  logic               uses_rs2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [XLEN-1:0]    pc_out,
  output logic [XLEN-1:0]    rs1_out,
  output logic [XLEN-1:0]    rs2_out,
  output logic [XLEN-1:0]    imm_out,
  output logic [FUNCT_W-1:0] funct_out,
  output logic [RD_W-1:0]    rd_out,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic               valid_q, valid_d;
  logic [CTRL_W-1:0]  ctrl_q,  ctrl_d;
  logic [XLEN-1:0]    pc_q,    pc_d;
  logic [XLEN-1:0]    rs1_q,   rs1_d;
  logic [XLEN-1:0]    rs2_q,   rs2_d;
  logic [XLEN-1:0]    imm_q,   imm_d;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic [RD_W-1:0]    rd_q,    rd_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic hazard;
  logic load;

`ifdef LOAD_USE_HAZARD_EN
  // A held load (MemRead = ctrl[5]) writes a register that the instruction
  // now in decode reads. Refusing it for one cycle lets the load drain, and
  // the drain leaves a bubble behind it. On the next cycle out_valid is 0,
  // so the hazard clears by itself.
  assign hazard = valid_q && ctrl_q[5] && (rd_q != '0) &&
                  ((rd_q == rs1_addr) || (uses_rs2 && (rd_q == rs2_addr)));
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{rs1_addr, rs2_addr, uses_rs2};
  assign hazard = 1'b0;
`endif

  assign in_ready = (!valid_q || out_ready) && !hazard;
  assign load     = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    funct_d = funct_q;
    rd_d    = rd_q;

    if (flush) begin
      // A handshake in the same cycle is still accepted upstream, but it is dropped here.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_in;
      pc_d    = pc_in;
      rs1_d   = rs1_data;
      rs2_d   = rs2_data;
      imm_d   = imm_in;
      funct_d = funct_in;
      rd_d    = rd_in;
    end else if (out_ready) begin
      // Drain: the entry leaves with no replacement, so a NOP bubble is issued.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && !in_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      funct_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      funct_q <= funct_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign ctrl_out  = ctrl_q;
  assign pc_out    = pc_q;
  assign rs1_out   = rs1_q;
  assign rs2_out   = rs2_q;
  assign imm_out   = imm_q;
  assign funct_out = funct_q;
  assign rd_out    = rd_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, out_ready, uses_rs2;
  logic [7:0]      ctrl_in;
  logic [XLEN-1:0] pc_in, rs1_data, rs2_data, imm_in;
  logic [3:0]      funct_in;
  logic [4:0]      rd_in, rs1_addr, rs2_addr;

  logic            in_ready, out_valid;
  logic [7:0]      ctrl_out;
  logic [XLEN-1:0] pc_out, rs1_out, rs2_out, imm_out;
  logic [3:0]      funct_out;
  logic [4:0]      rd_out;
  logic [15:0]     stall_cnt;

  logic            in_ready4, out_valid4;
  logic [7:0]      ctrl_out4;
  logic [XLEN-1:0] pc_out4, rs1_out4, rs2_out4, imm_out4;
  logic [3:0]      funct_out4;
  logic [4:0]      rd_out4;
  logic [3:0]      stall_cnt4;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .pc_in(pc_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm_in(imm_in), .funct_in(funct_in), .rd_in(rd_in), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .uses_rs2(uses_rs2), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .pc_out(pc_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .imm_out(imm_out), .funct_out(funct_out), .rd_out(rd_out), .stall_cnt(stall_cnt)
  );

  // Second instance with a 4-bit counter, used to check saturation.
  id_ex_pipe_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .ctrl_in(ctrl_in), .pc_in(pc_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm_in(imm_in), .funct_in(funct_in), .rd_in(rd_in), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .uses_rs2(uses_rs2), .out_valid(out_valid4), .out_ready(out_ready),
    .ctrl_out(ctrl_out4), .pc_out(pc_out4), .rs1_out(rs1_out4), .rs2_out(rs2_out4),
    .imm_out(imm_out4), .funct_out(funct_out4), .rd_out(rd_out4), .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction on the decode side.
  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [7:0] ctrl,
                       input logic [4:0] rd, input logic [4:0] a1, input logic ordy);
    in_valid  = v;
    pc_in     = pc;
    ctrl_in   = ctrl;
    rd_in     = rd;
    rs1_addr  = a1;
    rs1_data  = pc ^ 64'hA5A5_0000_0000_0001;
    rs2_data  = pc ^ 64'h5A5A_0000_0000_0002;
    imm_in    = pc + 64'd16;
    funct_in  = pc[5:2];
    out_ready = ordy;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; uses_rs2 = 1'b0; rs2_addr = 5'd31;
    drive(1'b0, 64'h0, 8'h00, 5'd0, 5'd0, 1'b0);
    tick(); tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_pc", pc_out, 64'd0);
    chk("rst_cnt", {48'd0, stall_cnt}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b1;
    tick();

    // T2: back-to-back stream with out_ready held high.
    drive(1'b1, 64'h100, 8'h82, 5'd1, 5'd9, 1'b1);
    tick();
    chk("t2_pc0", pc_out, 64'h100);
    chk("t2_valid0", {63'd0, out_valid}, 64'd1);
    chk("t2_ctrl0", {56'd0, ctrl_out}, 64'h82);
    chk("t2_imm0", imm_out, 64'h110);
    drive(1'b1, 64'h104, 8'h83, 5'd2, 5'd9, 1'b1);
    tick();
    chk("t2_pc1", pc_out, 64'h104);
    chk("t2_rd1", {59'd0, rd_out}, 64'd2);
    drive(1'b1, 64'h108, 8'h84, 5'd3, 5'd9, 1'b1);
    tick();
    chk("t2_pc2", pc_out, 64'h108);
    chk("t2_funct2", {60'd0, funct_out}, 64'h2);

    // T3: backpressure for three cycles.
    drive(1'b1, 64'h10C, 8'h85, 5'd4, 5'd9, 1'b0);
    #1;
    chk("t3_ready", {63'd0, in_ready}, 64'd0);
    tick(); tick(); tick();
    chk("t3_pc_frozen", pc_out, 64'h108);
    chk("t3_ctrl_frozen", {56'd0, ctrl_out}, 64'h84);
    chk("t3_valid", {63'd0, out_valid}, 64'd1);
    chk("t3_cnt", {48'd0, stall_cnt}, 64'd3);
    chk("t3_cnt4", {60'd0, stall_cnt4}, 64'd3);

    // T1: reset asserted in the middle of the stall.
    reset = 1'b0;
    #1;
    chk("t1_valid", {63'd0, out_valid}, 64'd0);
    chk("t1_ctrl", {56'd0, ctrl_out}, 64'd0);
    chk("t1_pc", pc_out, 64'd0);
    chk("t1_cnt", {48'd0, stall_cnt}, 64'd0);
    chk("t1_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b0, 64'h0, 8'h00, 5'd0, 5'd9, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    chk("t1_rel_ready", {63'd0, in_ready}, 64'd1);
    chk("t1_rel_valid", {63'd0, out_valid}, 64'd0);

    // T4: flush drops the entry that handshakes in the same cycle.
    drive(1'b1, 64'h1F0, 8'h80, 5'd7, 5'd9, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 64'h200, 8'h44, 5'd8, 5'd9, 1'b1);
    tick();
    flush = 1'b0;
    chk("t4_valid", {63'd0, out_valid}, 64'd0);
    chk("t4_ctrl", {56'd0, ctrl_out}, 64'd0);
    chk("t4_no200", {63'd0, (pc_out == 64'h200)}, 64'd0);
    drive(1'b0, 64'h0, 8'h00, 5'd0, 5'd9, 1'b1);
    tick();
    chk("t4_after_valid", {63'd0, out_valid}, 64'd0);
    chk("t4_after_no200", {63'd0, (pc_out == 64'h200)}, 64'd0);

    // T5: a load with rd=5, followed by a consumer that reads rs1=5.
    drive(1'b1, 64'h300, 8'hB0, 5'd5, 5'd9, 1'b1);
    tick();
    chk("t5_load_rd", {59'd0, rd_out}, 64'd5);
    drive(1'b1, 64'h304, 8'h82, 5'd6, 5'd5, 1'b1);
    #1;
`ifdef LOAD_USE_HAZARD_EN
    chk("t5_hz_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("t5_bubble_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_bubble_ctrl", {56'd0, ctrl_out}, 64'd0);
    chk("t5_hz_cleared", {63'd0, in_ready}, 64'd1);
`else
    chk("t5_hz_ready", {63'd0, in_ready}, 64'd1);
`endif
    tick();
    chk("t5_use_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_use_pc", pc_out, 64'h304);
    // A load that targets x0 never causes a bubble.
    drive(1'b1, 64'h310, 8'hB0, 5'd0, 5'd9, 1'b1);
    tick();
    drive(1'b1, 64'h314, 8'h82, 5'd6, 5'd0, 1'b1);
    #1;
    chk("t5_x0_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("t5_x0_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_x0_pc", pc_out, 64'h314);

    // T6: a long stall saturates the 4-bit counter.
    drive(1'b1, 64'h400, 8'h81, 5'd9, 5'd9, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("t6_cnt4_sat", {60'd0, stall_cnt4}, 64'd15);
`ifdef LOAD_USE_HAZARD_EN
    chk("t6_cnt16", {48'd0, stall_cnt}, 64'd21);
`else
    chk("t6_cnt16", {48'd0, stall_cnt}, 64'd20);
`endif
    tick(); tick(); tick();
    chk("t6_cnt4_stays", {60'd0, stall_cnt4}, 64'd15);
    chk("t6_pc_frozen", pc_out, 64'h314);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
